// File: rtl/pes_icm_pkg.sv
// Shared encodings and helpers for the pes_icm interrupt cascade master.
package pes_icm_pkg;

    localparam int ID_W = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_VEC     = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    localparam logic [1:0] DEF_VEC_TAG = 2'b10;
    localparam logic [1:0] DEF_EOI_TAG = 2'b01;

    // Increment a slave index, wrapping at the slave count.
    function automatic logic [ID_W-1:0] wrap_inc(
        input logic [ID_W-1:0] i,
        input logic [ID_W:0]   n
    );
        logic [ID_W:0] s;
        s = {1'b0, i} + 1'b1;
        if (s >= n) s = '0;
        return s[ID_W-1:0];
    endfunction

endpackage

// File: rtl/pes_icm_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr.
module pes_icm_rr_arb
    import pes_icm_pkg::*;
#(
    parameter int NUM_SLV = 4
) (
    input  logic [NUM_SLV-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               vld,
    output logic [ID_W-1:0]    idx
);

    localparam logic [ID_W:0] SLV_N = NUM_SLV[ID_W:0];

    logic [NUM_SLV-1:0] win;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;

    // Rotate so bit 0 is the slave at the pointer.
    assign win = NUM_SLV'({req, req} >> ptr);

    always_comb begin
        off = '0;
        vld = |req;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (win[i]) off = ID_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SLV_N) sum = sum - SLV_N;
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/pes_icm_cascade.sv
// Cascade master: shares one processor IRQ line and bus among pes_ic slaves.
// Optional REQ watchdog enabled by defining PES_ICM_TIMEOUT_EN.
module pes_icm_cascade
    import pes_icm_pkg::*;
#(
    parameter int         NUM_SLV = 4,
    parameter logic [1:0] VEC_TAG = DEF_VEC_TAG,
`ifdef PES_ICM_TIMEOUT_EN
    parameter logic [1:0] EOI_TAG = DEF_EOI_TAG,
    parameter int         TIMEOUT = 255
`else
    parameter logic [1:0] EOI_TAG = DEF_EOI_TAG
`endif
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_SLV-1:0]      slv_intr,
    input  logic [ID_W*NUM_SLV-1:0] slv_id,
    output logic [NUM_SLV-1:0]      slv_ack,
    output logic [NUM_SLV-1:0]      slv_eoi,
    output logic                    intr_out,
    input  logic                    intr_in,
    input  logic [7:0]              bus_in,
    output logic [7:0]              bus_out,
    output logic                    bus_oe,
    output logic                    grant_vld,
    output logic [ID_W-1:0]         grant_idx,
    output logic                    err_eoi
);

    localparam logic [ID_W:0] SLV_N = NUM_SLV[ID_W:0];

    logic [1:0]         state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SLV-1:0] grant_oh;

    logic               arb_vld;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W-1:0]    id_pick;
    logic [NUM_SLV-1:0] arb_oh;
    logic               pend;
    logic               tmo;
    logic               unused_bits;

    assign unused_bits = ^bus_in[2:0];

    pes_icm_rr_arb #(.NUM_SLV(NUM_SLV)) u_arb (
        .req (slv_intr),
        .ptr (ptr),
        .vld (arb_vld),
        .idx (arb_idx)
    );

    always_comb begin
        id_pick = '0;
        arb_oh  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (arb_idx == ID_W'(i)) begin
                id_pick   = slv_id[ID_W*i +: ID_W];
                arb_oh[i] = 1'b1;
            end
        end
    end

    assign pend      = |(slv_intr & grant_oh);
    assign intr_out  = (state == ST_REQ);
    assign bus_oe    = (state == ST_VEC);
    assign grant_vld = (state != ST_IDLE);

`ifdef PES_ICM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tmo_cnt <= '0;
        end else if (state == ST_REQ && pend && intr_in && !tmo) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            irq_id    <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            slv_ack   <= '0;
            slv_eoi   <= '0;
            bus_out   <= '0;
            err_eoi   <= 1'b0;
        end else begin
            slv_ack <= '0;
            slv_eoi <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        state     <= ST_REQ;
                        grant_idx <= arb_idx;
                        irq_id    <= id_pick;
                        grant_oh  <= arb_oh;
                    end
                end
                ST_REQ: begin
                    // A withdrawn request wins over a coincident ack.
                    if (!pend) begin
                        state <= ST_IDLE;
                    end else if (!intr_in) begin
                        state   <= ST_VEC;
                        slv_ack <= grant_oh;
                        bus_out <= {VEC_TAG, grant_idx, irq_id};
                    end else if (tmo) begin
                        state <= ST_IDLE;
                        ptr   <= wrap_inc(grant_idx, SLV_N);
                    end
                end
                ST_VEC: begin
                    if (!intr_in) begin
                        state   <= ST_SERVICE;
                        bus_out <= '0;
                    end
                end
                ST_SERVICE: begin
                    if (!intr_in && bus_in[7:6] == EOI_TAG) begin
                        if (bus_in[5:3] == grant_idx) begin
                            state   <= ST_IDLE;
                            slv_eoi <= grant_oh;
                            ptr     <= wrap_inc(grant_idx, SLV_N);
                        end else begin
                            err_eoi <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pes_icm_cascade.sv
// Directed bench for pes_icm_cascade; watchdog case runs with PES_ICM_TIMEOUT_EN.
module tb_pes_icm_cascade;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  slv_intr;
    logic [11:0] slv_id;
    logic [3:0]  slv_ack;
    logic [3:0]  slv_eoi;
    logic        intr_out;
    logic        intr_in;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        grant_vld;
    logic [2:0]  grant_idx;
    logic        err_eoi;

    int n_chk = 0;
    int n_err = 0;

    pes_icm_cascade #(.NUM_SLV(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .slv_intr  (slv_intr),
        .slv_id    (slv_id),
        .slv_ack   (slv_ack),
        .slv_eoi   (slv_eoi),
        .intr_out  (intr_out),
        .intr_in   (intr_in),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .err_eoi   (err_eoi)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe();
        intr_in = 1'b0;
        tick();
        intr_in = 1'b1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    // One full handshake from IDLE for slave idx carrying IRQ id.
    task automatic run_seq(input logic [2:0] idx, input logic [2:0] id);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        tick();
        chk("req_intr", intr_out, 1);
        chk("req_vld", grant_vld, 1);
        chk("req_idx", grant_idx, idx);
        strobe();
        chk("vec_oe", bus_oe, 1);
        chk("vec_intr", intr_out, 0);
        chk("vec_bus", bus_out, {2'b10, idx, id});
        chk("vec_ack", slv_ack, oh);
        strobe();
        chk("svc_oe", bus_oe, 0);
        chk("svc_bus", bus_out, 0);
        chk("svc_ack", slv_ack, 0);
        bus_in = {2'b01, idx, 3'b000};
        strobe();
        chk("eoi_pulse", slv_eoi, oh);
        chk("eoi_vld", grant_vld, 0);
    endtask

    initial begin
        rst_in   = 1'b0;
        slv_intr = '0;
        slv_id   = '0;
        intr_in  = 1'b1;
        bus_in   = '0;
        do_reset();
        chk("rst_intr", intr_out, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_vld", grant_vld, 0);
        chk("rst_err", err_eoi, 0);
        chk("rst_bus", bus_out, 0);

        // Single slave 2, id 5.
        slv_intr = 4'b0100;
        slv_id   = 12'd5 << 6;
        run_seq(3'd2, 3'd5);
        chk("t1_vecword", 8'b10_010_101, {2'b10, 3'd2, 3'd5});
        slv_intr = '0;
        tick();
        chk("t1_eoi_clr", slv_eoi, 0);
        chk("t1_idle", grant_vld, 0);

        // All pending: rotation 0,1,2,3,0.
        do_reset();
        slv_id   = {3'd7, 3'd6, 3'd5, 3'd4};
        slv_intr = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_seq(3'(k % 4), 3'(4 + k % 4));
        end
        slv_intr = '0;

        // Wrong-index EOI sets sticky error.
        do_reset();
        slv_intr = 4'b0010;
        tick();
        chk("t3_idx", grant_idx, 1);
        strobe();
        strobe();
        bus_in = 8'b11_001_000;
        strobe();
        chk("t3_othertag_vld", grant_vld, 1);
        chk("t3_othertag_err", err_eoi, 0);
        bus_in = 8'b01_011_000;
        strobe();
        chk("t3_err", err_eoi, 1);
        chk("t3_noeoi", slv_eoi, 0);
        chk("t3_stay", grant_vld, 1);
        bus_in = 8'b01_001_111;
        strobe();
        chk("t3_eoi", slv_eoi, 4'b0010);
        chk("t3_done", grant_vld, 0);
        chk("t3_sticky", err_eoi, 1);

        // Drop in REQ leaves pointer at 2.
        slv_intr = 4'b0100;
        tick();
        chk("t4_req", grant_idx, 2);
        chk("t4_intr", intr_out, 1);
        slv_intr = '0;
        tick();
        chk("t4_drop_intr", intr_out, 0);
        chk("t4_drop_vld", grant_vld, 0);
        slv_intr = 4'b0110;
        tick();
        chk("t4_regrant", grant_idx, 2);

        // Reset during VEC.
        strobe();
        chk("t5_vec", bus_oe, 1);
        slv_intr = 4'b1111;
        rst_in = 1'b0;
        tick();
        chk("t5_oe", bus_oe, 0);
        chk("t5_intr", intr_out, 0);
        chk("t5_vld", grant_vld, 0);
        chk("t5_err", err_eoi, 0);
        rst_in = 1'b1;
        tick();
        chk("t5_restart", grant_idx, 0);
        chk("t5_restart_intr", intr_out, 1);

`ifdef PES_ICM_TIMEOUT_EN
        do_reset();
        slv_intr = 4'b0011;
        tick();
        chk("t6_idx0", grant_idx, 0);
        repeat (254) tick();
        chk("t6_hold", intr_out, 1);
        tick();
        chk("t6_drop", intr_out, 0);
        chk("t6_vld", grant_vld, 0);
        tick();
        chk("t6_next", grant_idx, 1);
        chk("t6_next_intr", intr_out, 1);
`else
        do_reset();
        slv_intr = 4'b0001;
        tick();
        repeat (300) tick();
        chk("t6_wait_intr", intr_out, 1);
        chk("t6_wait_vld", grant_vld, 1);
        chk("t6_wait_idx", grant_idx, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
